// File: rtl/pe_pkg.sv
// Definitions shared by the operand feeder and the serial PE: element width,
// feeder FSM states and the bit positions inside pe_ctl.
package pe_pkg;

    localparam int DW = 16;

    // pe_ctl bit positions
    localparam int CTL_FIRST = 0;  // PE loads the product and drops its accumulator
    localparam int CTL_LAST  = 1;  // PE emits its accumulated result

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Pairs in one job: elements per dot product times dot products per job
    function automatic logic [15:0] job_total(input logic [7:0] len, input logic [7:0] num);
        return 16'(len) * 16'(num);
    endfunction

endpackage

// File: rtl/pe_feeder_if.sv
// Job control, operand input stream and PE operand output bundle of pe_feeder.
//
// Handshake rule for the input stream: a pair moves on a rising edge where
// in_vld and in_rdy are both high. in_rdy never depends on in_vld. Once in_vld
// is raised, the source holds it and the operands stable until the transfer.
// The PE side has no back-pressure: pe_vld marks a valid operand cycle.
interface pe_feeder_if #(
    parameter int DW = pe_pkg::DW
);
    import pe_pkg::*;

    logic                 start;
    logic [7:0]           cfg_len;
    logic [7:0]           cfg_num;
    logic                 in_vld;
    logic                 in_rdy;
    logic signed [DW-1:0] in_neuron;
    logic signed [DW-1:0] in_weight;
    logic [DW-1:0]        pe_neuron;
    logic [DW-1:0]        pe_weight;
    logic [1:0]           pe_ctl;
    logic                 pe_vld;
    logic                 busy;
    logic                 done;
    state_t               dbg_state;

    // Feeder side
    modport slave (
        input  start, cfg_len, cfg_num, in_vld, in_neuron, in_weight,
        output in_rdy, pe_neuron, pe_weight, pe_ctl, pe_vld, busy, done, dbg_state
    );

    // Job controller / operand source side
    modport master (
        output start, cfg_len, cfg_num, in_vld, in_neuron, in_weight,
        input  in_rdy, pe_neuron, pe_weight, pe_ctl, pe_vld, busy, done, dbg_state
    );

endinterface

// File: rtl/pe_pair_fifo.sv
// Synchronous FIFO for {neuron, weight} operand pairs. Read data is the
// registered head entry; a pair written this cycle is only visible from the
// next cycle (no pass-through). DEPTH must be a power of two, at least 2.
module pe_pair_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Operand feeder for a serial dot-product PE. Buffers incoming neuron/weight
// pairs, then issues one pair per cycle with first/last element markers so the
// PE knows when to restart its accumulator and when to emit a result.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int DW         = pe_pkg::DW,
    parameter int FIFO_DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    pe_feeder_if.slave bus
);

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      len_q;
    logic [7:0]      num_q;
    logic [15:0]     total_q;
    logic [15:0]     loaded_q;
    logic [7:0]      elem_q;
    logic [7:0]      vec_q;

    logic [DW-1:0]   pe_neuron_q;
    logic [DW-1:0]   pe_weight_q;
    logic [1:0]      pe_ctl_q;
    logic            pe_vld_q;
    logic            pe_final_q;

    logic            start_ok;
    logic            zero_job;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [2*DW-1:0] fifo_rd;
    logic            elem_last;
    logic            vec_last;
    logic [1:0]      ctl_nxt;

    assign start_ok  = (state == IDLE) && bus.start;
    assign zero_job  = (bus.cfg_len == 8'd0) || (bus.cfg_num == 8'd0);

    // Acceptance looks only at registered state so in_rdy has no in_vld path
    assign bus.in_rdy = (state == RUN) && !full && (loaded_q < total_q);
    assign push       = bus.in_vld && bus.in_rdy;
    assign pop        = (state == RUN) && !empty;

    assign elem_last = (elem_q == (len_q - 8'd1));
    assign vec_last  = (vec_q == (num_q - 8'd1));

    pe_pair_fifo #(
        .W     (2 * DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({bus.in_neuron, bus.in_weight}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (full),
        .empty   (empty)
    );

    // Control bits for the pair being popped this cycle
    always_comb begin
        ctl_nxt            = '0;
        ctl_nxt[CTL_FIRST] = (elem_q == 8'd0);
        ctl_nxt[CTL_LAST]  = elem_last;
    end

    // Next state: a zero-length job skips RUN; RUN ends once the final pair is on pe_*
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = zero_job ? FIN : RUN;
                end
            end
            RUN: begin
                if (pe_vld_q && pe_final_q) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job configuration and load counter; total is latched once per job
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            num_q    <= '0;
            total_q  <= '0;
            loaded_q <= '0;
        end else if (start_ok) begin
            len_q    <= bus.cfg_len;
            num_q    <= bus.cfg_num;
            total_q  <= job_total(bus.cfg_len, bus.cfg_num);
            loaded_q <= '0;
        end else if (push) begin
            loaded_q <= loaded_q + 16'd1;
        end
    end

    // Element and vector position; both advance only when a pair is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q <= '0;
            vec_q  <= '0;
        end else if (start_ok) begin
            elem_q <= '0;
            vec_q  <= '0;
        end else if (pop) begin
            if (elem_last) begin
                elem_q <= '0;
                vec_q  <= vec_q + 8'd1;
            end else begin
                elem_q <= elem_q + 8'd1;
            end
        end
    end

    // Registered PE operands; cycles without a pop drive an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_vld_q    <= 1'b0;
            pe_ctl_q    <= '0;
            pe_neuron_q <= '0;
            pe_weight_q <= '0;
            pe_final_q  <= 1'b0;
        end else if (pop) begin
            pe_vld_q    <= 1'b1;
            pe_ctl_q    <= ctl_nxt;
            pe_neuron_q <= fifo_rd[2*DW-1:DW];
            pe_weight_q <= fifo_rd[DW-1:0];
            pe_final_q  <= elem_last && vec_last;
        end else begin
            pe_vld_q    <= 1'b0;
            pe_ctl_q    <= '0;
            pe_neuron_q <= '0;
            pe_weight_q <= '0;
            pe_final_q  <= 1'b0;
        end
    end

    assign bus.pe_vld    = pe_vld_q;
    assign bus.pe_ctl    = pe_ctl_q;
    assign bus.pe_neuron = pe_neuron_q;
    assign bus.pe_weight = pe_weight_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: scenario tasks drive jobs and operand pairs; a monitor
// compares every issued pair against the expected queue and runs a PE model.
module tb_pe_feeder;
    import pe_pkg::*;

    localparam int TDW = 16;
    localparam int EW  = 2 + 2 * TDW;

    logic clk = 1'b0;
    logic rst;

    pe_feeder_if #(.DW(TDW)) bus ();

    pe_feeder #(
        .DW         (TDW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [EW-1:0]    exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               issue_cnt = 0;
    int               done_cnt = 0;
    int               bubble_cnt = 0;
    int               first_issue_cyc = 0;
    int               last_issue_cyc = 0;
    int               done_cyc = 0;
    int               accepted = 0;
    int               stall_cnt = 0;
    logic signed [31:0] acc = 0;
    logic signed [31:0] last_result = 0;

    function automatic logic [1:0] exp_ctl(input int k, input int len);
        logic [1:0] c;
        c[0] = ((k % len) == 0);
        c[1] = ((k % len) == (len - 1));
        return c;
    endfunction

    // Monitor: samples 2 time units after each rising edge
    always begin
        logic [EW-1:0]        exp;
        logic signed [TDW-1:0] mn;
        logic signed [TDW-1:0] mw;
        logic signed [31:0]   prod;
        @(posedge clk);
        #2;
        cyc++;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.pe_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got ctl=%b n=%h w=%h, required no pe_vld",
                         bus.pe_ctl, bus.pe_neuron, bus.pe_weight);
            end else begin
                exp = exp_q.pop_front();
                if ({bus.pe_ctl, bus.pe_neuron, bus.pe_weight} !== exp) begin
                    errors++;
                    $display("FAIL issue_data: got ctl=%b n=%h w=%h, required ctl=%b n=%h w=%h",
                             bus.pe_ctl, bus.pe_neuron, bus.pe_weight,
                             exp[EW-1:EW-2], exp[2*TDW-1:TDW], exp[TDW-1:0]);
                end
            end
            mn   = bus.pe_neuron;
            mw   = bus.pe_weight;
            prod = mn * mw;
            if (bus.pe_ctl[0]) acc = prod;
            else               acc = acc + prod;
            if (bus.pe_ctl[1]) last_result = acc;
            issue_cnt++;
            if (issue_cnt == 1) first_issue_cyc = cyc;
            last_issue_cyc = cyc;
        end else begin
            if (bus.dbg_state == RUN) bubble_cnt++;
            checks++;
            if ({bus.pe_ctl, bus.pe_neuron, bus.pe_weight} !== '0) begin
                errors++;
                $display("FAIL bubble_zero: got ctl=%b n=%h w=%h, required all 0",
                         bus.pe_ctl, bus.pe_neuron, bus.pe_weight);
            end
        end
    end

    // Driver tasks; all start and end on a falling edge
    task automatic clear_stats();
        issue_cnt  = 0;
        done_cnt   = 0;
        bubble_cnt = 0;
        accepted   = 0;
        stall_cnt  = 0;
    endtask

    task automatic do_start(input logic [7:0] len, input logic [7:0] num);
        bus.start   = 1'b1;
        bus.cfg_len = len;
        bus.cfg_num = num;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic push_pair(input logic [TDW-1:0] n, input logic [TDW-1:0] w,
                             input logic [1:0] ctl);
        int t = 0;
        bus.in_vld    = 1'b1;
        bus.in_neuron = n;
        bus.in_weight = w;
        while (!bus.in_rdy && t < 100) begin
            @(negedge clk);
            t++;
            stall_cnt++;
        end
        checks++;
        if (!bus.in_rdy) begin
            errors++;
            $display("FAIL accept_timeout: got in_rdy=0 after %0d cycles, required 1", t);
        end else begin
            exp_q.push_back({ctl, n, w});
            accepted++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a pulse", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    // Scenarios
    task automatic test_reset();
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.cfg_len = 8'd2;
        bus.cfg_num = 8'd1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_rdy, bus.pe_vld, bus.pe_ctl, bus.pe_neuron, bus.pe_weight,
             bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b ctl=%b busy=%b done=%b, required 0",
                     bus.in_rdy, bus.pe_vld, bus.pe_ctl, bus.busy, bus.done);
        end
        checks++;
        if (bus.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_over_start: got state=%0d, required IDLE", bus.dbg_state);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_release: got busy=%b state=%0d, required 0/IDLE",
                     bus.busy, bus.dbg_state);
        end
    endtask

    task automatic test_basic();
        clear_stats();
        do_start(8'd3, 8'd1);
        push_pair(16'd5, 16'd3, 2'b01);
        push_pair(16'd2, 16'd4, 2'b00);
        push_pair(-16'sd1, 16'd7, 2'b10);
        bus.in_vld = 1'b0;
        wait_done(20);
        checks++;
        if (issue_cnt != 3) begin
            errors++;
            $display("FAIL basic_issues: got %0d, required 3", issue_cnt);
        end
        checks++;
        if (last_result !== 32'sd16) begin
            errors++;
            $display("FAIL basic_dot: got %h, required %h", last_result, 32'sd16);
        end
        checks++;
        if (last_issue_cyc - first_issue_cyc != 2) begin
            errors++;
            $display("FAIL basic_contiguous: got span %0d, required 2",
                     last_issue_cyc - first_issue_cyc);
        end
        checks++;
        if (done_cyc - last_issue_cyc != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done: got delay %0d count %0d, required 1/1",
                     done_cyc - last_issue_cyc, done_cnt);
        end
    endtask

    task automatic test_len1();
        clear_stats();
        do_start(8'd1, 8'd4);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                bus.start   = 1'b1;   // must be ignored while running
                bus.cfg_len = 8'd3;
                bus.cfg_num = 8'd2;
            end
            push_pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 2'b11);
            bus.start = 1'b0;
        end
        bus.in_vld = 1'b0;
        wait_done(20);
        checks++;
        if (issue_cnt != 4) begin
            errors++;
            $display("FAIL len1_issues: got %0d, required 4", issue_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL len1_done_count: got %0d, required 1", done_cnt);
        end
    endtask

    task automatic test_toggle();
        clear_stats();
        do_start(8'd4, 8'd2);
        for (int k = 0; k < 8; k++) begin
            push_pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      exp_ctl(k, 4));
            bus.in_vld = 1'b0;
            @(negedge clk);
        end
        wait_done(30);
        checks++;
        if (issue_cnt != 8) begin
            errors++;
            $display("FAIL toggle_issues: got %0d, required 8", issue_cnt);
        end
        checks++;
        if (bubble_cnt == 0) begin
            errors++;
            $display("FAIL toggle_bubbles: got %0d bubbles, required more than 0", bubble_cnt);
        end
    endtask

    task automatic test_backpressure();
        clear_stats();
        do_start(8'd6, 8'd1);
        for (int k = 0; k < 6; k++) begin
            push_pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      exp_ctl(k, 6));
        end
        for (int j = 0; j < 2; j++) begin
            bus.in_vld = 1'b1;
            checks++;
            if (bus.in_rdy !== 1'b0) begin
                errors++;
                accepted++;
                $display("FAIL bp_over_accept: got in_rdy=%b after 6 pairs, required 0", bus.in_rdy);
            end
            @(negedge clk);
        end
        bus.in_vld = 1'b0;
        wait_done(20);
        checks++;
        if (accepted != 6 || stall_cnt != 0) begin
            errors++;
            $display("FAIL bp_accept: got accepted=%0d stalls=%0d, required 6/0",
                     accepted, stall_cnt);
        end
        checks++;
        if (issue_cnt != 6) begin
            errors++;
            $display("FAIL bp_issues: got %0d, required 6", issue_cnt);
        end
    endtask

    task automatic test_zero();
        clear_stats();
        for (int v = 0; v < 2; v++) begin
            bus.in_vld    = 1'b1;
            bus.in_neuron = 16'h1234;
            bus.in_weight = 16'h5678;
            do_start((v == 0) ? 8'd0 : 8'd3, (v == 0) ? 8'd5 : 8'd0);
            checks++;
            if (bus.done !== 1'b1 || bus.dbg_state !== FIN || bus.in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL zero_fin: got done=%b state=%0d rdy=%b, required 1/FIN/0",
                         bus.done, bus.dbg_state, bus.in_rdy);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.dbg_state !== IDLE || bus.in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL zero_idle: got done=%b state=%0d rdy=%b, required 0/IDLE/0",
                         bus.done, bus.dbg_state, bus.in_rdy);
            end
            bus.in_vld = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (issue_cnt != 0 || done_cnt != 2) begin
            errors++;
            $display("FAIL zero_summary: got issues=%0d dones=%0d, required 0/2",
                     issue_cnt, done_cnt);
        end
    endtask

    task automatic test_abort();
        clear_stats();
        do_start(8'd5, 8'd1);
        for (int k = 0; k < 3; k++) begin
            push_pair(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      exp_ctl(k, 5));
        end
        bus.in_vld = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (issue_cnt != 2) begin
            errors++;
            $display("FAIL abort_issues: got %0d before reset, required 2", issue_cnt);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (bus.pe_vld !== 1'b0 || bus.dbg_state !== IDLE) begin
                errors++;
                $display("FAIL abort_quiet: got vld=%b state=%0d, required 0/IDLE",
                         bus.pe_vld, bus.dbg_state);
            end
            @(negedge clk);
        end
        clear_stats();
        do_start(8'd2, 8'd1);
        push_pair(16'hA5A5, 16'h0F0F, 2'b01);
        push_pair(16'h8000, 16'h7FFF, 2'b10);
        bus.in_vld = 1'b0;
        wait_done(20);
        checks++;
        if (issue_cnt != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_rerun: got issues=%0d pending=%0d, required 2/0",
                     issue_cnt, exp_q.size());
        end
    endtask

    // Test sequence and report
    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.cfg_num   = '0;
        bus.in_vld    = 1'b0;
        bus.in_neuron = '0;
        bus.in_weight = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_len1();
        test_toggle();
        test_backpressure();
        test_zero();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
